// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder with a 32 x 16 register file.
// MDC is oversampled in the clk domain; the line is driven after MDC falls.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR   = 5'h10,
    parameter logic [15:0] CTRL_RST   = 16'h1140,
    parameter logic [15:0] STATUS_VAL = 16'h796D,
    parameter logic [15:0] ID1_VAL    = 16'h0141,
    parameter logic [15:0] ID2_VAL    = 16'h0CC2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        soft_rst
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHY,
        S_SKIP,
        S_REG,
        S_TA,
        S_RDAT,
        S_WDAT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  mdc_q;
    logic [1:0]  mdio_q;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] sh_q, sh_d;
    logic        rd_q, rd_d;
    logic [4:0]  reg_q, reg_d;
    logic [15:0] rdat_q, rdat_d;
    logic        oen_q, oen_d;
    logic        out_q, out_d;
    logic        stb_q, stb_d;
    logic        srst_q, srst_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rf_q [32];

    logic        rise, fall, bit_s, commit;
    logic [4:0]  reg_sel;
    logic [15:0] wdat;
    logic [15:0] rd_word;

    assign rise    = mdc_q[1] & ~mdc_q[2];
    assign fall    = ~mdc_q[1] & mdc_q[2];
    assign bit_s   = mdio_q[1];
    assign reg_sel = {sh_q[3:0], bit_s};
    assign wdat    = {sh_q[14:0], bit_s};

    assign mdio_out  = out_q;
    assign mdio_oen  = oen_q;
    assign wr_strobe = stb_q;
    assign wr_addr   = waddr_q;
    assign wr_data   = wdata_q;
    assign soft_rst  = srst_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdc_q  <= '0;
            mdio_q <= 2'b11;
        end else begin
            mdc_q  <= {mdc_q[1:0], mdc};
            mdio_q <= {mdio_q[0], mdio_in};
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            rd_q    <= 1'b0;
            reg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rd_q    <= rd_d;
            reg_q   <= reg_d;
        end
    end

    // next-state logic; the shift register sees every sampled bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rd_d    = rd_q;
        reg_d   = reg_q;
        commit  = 1'b0;
        if (rise) begin
            sh_d  = wdat;
            cnt_d = cnt_q + 6'd1;
            unique case (state_q)
                S_IDLE: begin
                    if (bit_s) begin
                        cnt_d = (cnt_q == 6'd32) ? cnt_q : cnt_q + 6'd1;
                    end else begin
                        cnt_d = '0;
                        if (cnt_q == 6'd32) state_d = S_ST;
                    end
                end
                S_ST: begin
                    cnt_d   = '0;
                    state_d = bit_s ? S_OP : S_IDLE;
                end
                S_OP: begin
                    if (cnt_q == 6'd1) begin
                        cnt_d   = '0;
                        rd_d    = sh_q[0];
                        state_d = (sh_q[0] ^ bit_s) ? S_PHY : S_IDLE;
                    end
                end
                S_PHY: begin
                    if (cnt_q == 6'd4) begin
                        cnt_d   = '0;
                        state_d = (reg_sel == PHY_ADDR) ? S_REG : S_SKIP;
                    end
                end
                S_SKIP: begin
                    if (cnt_q == 6'd17) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                S_REG: begin
                    if (cnt_q == 6'd4) begin
                        cnt_d   = '0;
                        reg_d   = reg_sel;
                        state_d = S_TA;
                    end
                end
                S_TA: begin
                    if (!rd_q && cnt_q == 6'd1) begin
                        cnt_d   = '0;
                        state_d = S_WDAT;
                    end
                end
                S_RDAT: begin
                end
                S_WDAT: begin
                    if (cnt_q == 6'd15) begin
                        cnt_d   = '0;
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end else if (fall && rd_q) begin
            if (state_q == S_TA && cnt_q == 6'd2) begin
                cnt_d   = '0;
                state_d = S_RDAT;
            end else if (state_q == S_RDAT && cnt_q == 6'd16) begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        end
    end

    always_comb begin
        unique case (reg_sel)
            5'd1:    rd_word = STATUS_VAL;
            5'd2:    rd_word = ID1_VAL;
            5'd3:    rd_word = ID2_VAL;
            default: rd_word = rf_q[reg_sel];
        endcase
    end

    // output logic: line drive and write-commit signals
    always_comb begin
        oen_d   = oen_q;
        out_d   = out_q;
        rdat_d  = rdat_q;
        stb_d   = 1'b0;
        srst_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (rise && state_q == S_REG && cnt_q == 6'd4) begin
            rdat_d = rd_word;
        end
        if (fall && rd_q) begin
            if (state_q == S_TA && cnt_q == 6'd1) begin
                oen_d = 1'b0;
                out_d = 1'b0;
            end else if ((state_q == S_TA && cnt_q == 6'd2) ||
                         (state_q == S_RDAT && cnt_q != 6'd16)) begin
                out_d  = rdat_q[15];
                rdat_d = {rdat_q[14:0], 1'b0};
            end else if (state_q == S_RDAT) begin
                oen_d = 1'b1;
                out_d = 1'b1;
            end
        end
        if (commit) begin
            stb_d   = 1'b1;
            srst_d  = (reg_q == 5'd0) & wdat[15];
            waddr_d = reg_q;
            wdata_d = wdat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oen_q   <= 1'b1;
            out_q   <= 1'b1;
            rdat_q  <= '0;
            stb_q   <= 1'b0;
            srst_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            oen_q   <= oen_d;
            out_q   <= out_d;
            rdat_q  <= rdat_d;
            stb_q   <= stb_d;
            srst_q  <= srst_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // reg 0 bit 15 self-clears; regs 1-3 are constants and never stored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_q[0] <= CTRL_RST;
            for (int i = 1; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (commit) begin
            if (reg_q == 5'd0) begin
                rf_q[0] <= {1'b0, wdat[14:0]};
            end else if (reg_q > 5'd3) begin
                rf_q[reg_q] <= wdat;
            end
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// Directed MDIO frames; a monitor checks read words and write commits
// against queued expectations.
module tb_mdio_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        mdc = 1'b0;
    logic        tb_drv = 1'b1;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_oen;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        soft_rst;

    typedef struct {
        int          n;
        logic [16:0] v;
    } rexp_t;

    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
        logic        s;
    } wexp_t;

    rexp_t rq[$];
    wexp_t wq[$];
    int    n_checks = 0;
    int    n_fail = 0;

    assign mdio_in = mdio_oen ? tb_drv : mdio_out;

    always #5 clk = ~clk;

    mdio_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mdc       (mdc),
        .mdio_in   (mdio_in),
        .mdio_out  (mdio_out),
        .mdio_oen  (mdio_oen),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .soft_rst  (soft_rst)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // one MDC period at clk/20; master changes the line while MDC is low
    task automatic mbit(input logic b);
        mdc = 1'b0;
        tb_drv = b;
        repeat (10) @(posedge clk);
        mdc = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic tail();
        mdc = 1'b0;
        tb_drv = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic frame(input int pre, input logic [1:0] op,
                         input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input int rst_at);
        for (int i = 0; i < pre; i++) mbit(1'b1);
        mbit(1'b0);
        mbit(1'b1);
        mbit(op[1]);
        mbit(op[0]);
        for (int i = 4; i >= 0; i--) mbit(pa[i]);
        for (int i = 4; i >= 0; i--) mbit(ra[i]);
        if (op == 2'b01) begin
            mbit(1'b1);
            mbit(1'b0);
            for (int i = 15; i >= 0; i--) mbit(wd[i]);
        end else begin
            for (int k = 0; k < 18; k++) begin
                if (rst_at > 0 && k - 1 == rst_at) begin
                    mdc = 1'b0;
                    tb_drv = 1'b1;
                    repeat (6) @(posedge clk);
                    #1;
                    chk("oen_before_rst", 32'(mdio_oen), 32'd0);
                    reset_n = 1'b0;
                    #1;
                    chk("oen_async_rst", 32'(mdio_oen), 32'd1);
                    repeat (4) @(posedge clk);
                    reset_n = 1'b1;
                    break;
                end
                mbit(1'b1);
            end
        end
        tail();
    endtask

    task automatic rd(input logic [4:0] ra, input logic [15:0] exp);
        rexp_t e;
        e.n = 17;
        e.v = {1'b0, exp};
        rq.push_back(e);
        frame(32, 2'b10, 5'h10, ra, 16'h0, 0);
    endtask

    task automatic wr(input logic [4:0] ra, input logic [15:0] d,
                      input logic s);
        wexp_t e;
        e.a = ra;
        e.d = d;
        e.s = s;
        wq.push_back(e);
        frame(32, 2'b01, 5'h10, ra, d, 0);
    endtask

    // monitor: sample driven bits at MDC rise, close a word on release
    logic        mdc_prev = 1'b0;
    logic        oen_prev = 1'b1;
    logic        stb_prev = 1'b0;
    int          nb = 0;
    logic [16:0] sh = '0;

    always @(negedge clk) begin
        rexp_t re;
        wexp_t we;
        if (mdc && !mdc_prev && !mdio_oen) begin
            sh = {sh[15:0], mdio_out};
            nb++;
        end
        if (mdio_oen && !oen_prev) begin
            if (rq.size() == 0) begin
                chk("read_unexpected", 32'(nb), 32'd0);
            end else begin
                re = rq.pop_front();
                chk("read_bits", 32'(nb), 32'(re.n));
                chk("read_data", 32'(sh), 32'(re.v));
            end
            nb = 0;
            sh = '0;
        end
        if (stb_prev) chk("strobe_width", 32'(wr_strobe), 32'd0);
        if (wr_strobe && !stb_prev) begin
            if (wq.size() == 0) begin
                chk("write_unexpected", 32'(wr_addr), 32'hffff_ffff);
            end else begin
                we = wq.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(we.a));
                chk("wr_data", 32'(wr_data), 32'(we.d));
                chk("soft_rst", 32'(soft_rst), 32'(we.s));
            end
        end else if (soft_rst) begin
            chk("soft_rst_stray", 32'(soft_rst), 32'd0);
        end
        mdc_prev = mdc;
        oen_prev = mdio_oen;
        stb_prev = wr_strobe;
    end

    initial begin
        rexp_t e;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oen", 32'(mdio_oen), 32'd1);
        chk("rst_out", 32'(mdio_out), 32'd1);
        chk("rst_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_soft", 32'(soft_rst), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        tail();

        rd(5'd1, 16'h796D);
        rd(5'd0, 16'h1140);
        wr(5'd9, 16'hA5C3, 1'b0);
        rd(5'd9, 16'hA5C3);
        wr(5'd0, 16'h9140, 1'b1);
        rd(5'd0, 16'h1140);
        wr(5'd31, 16'h0001, 1'b0);
        rd(5'd31, 16'h0001);
        rd(5'd4, 16'h0000);

        frame(32, 2'b10, 5'h03, 5'd2, 16'h0, 0);
        rd(5'd2, 16'h0141);

        frame(31, 2'b10, 5'h10, 5'd1, 16'h0, 0);
        frame(32, 2'b11, 5'h10, 5'd1, 16'h0, 0);
        rd(5'd3, 16'h0CC2);

        wr(5'd2, 16'hFFFF, 1'b0);
        rd(5'd2, 16'h0141);

        // reset during data bit 5: TA zero plus data bits 1-4 of 0xA5C3
        e.n = 5;
        e.v = 17'b0_1010;
        rq.push_back(e);
        frame(32, 2'b10, 5'h10, 5'd9, 16'h0, 5);
        chk("wr_addr_after_rst", 32'(wr_addr), 32'd0);
        rd(5'd9, 16'h0000);
        rd(5'd0, 16'h1140);

        repeat (20) @(posedge clk);
        chk("reads_outstanding", 32'(rq.size()), 32'd0);
        chk("writes_outstanding", 32'(wq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
